// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU load/store
// path and a debug/loader requester. Debug wins after MAX_WAIT denied cycles,
// and may hold the port for a bounded locked burst followed by one cooldown
// cycle in which the CPU is guaranteed the port.
module dm_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] DM_Address,
    output logic              DM_enable,
    output logic [DATA_W-1:0] DM_Write_Data,
    input  logic [DATA_W-1:0] DM_Read_Data
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned LOCK_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              cpu_owns;
    logic              dbg_read;

    // Grant and stall decision for the current cycle, driven by the arbiter state.
    always_comb begin
        dbg_gnt   = 1'b0;
        cpu_stall = 1'b0;
        case (state)
            ARB: begin
                dbg_gnt   = dbg_req & (~cpu_req | (wait_cnt == WAIT_SAT));
                cpu_stall = cpu_req & dbg_gnt;
            end
            LOCKED: begin
                dbg_gnt   = dbg_req;
                cpu_stall = cpu_req;
            end
            default: begin
                dbg_gnt   = 1'b0;
                cpu_stall = 1'b0;
            end
        endcase
    end

    assign cpu_owns = cpu_req & ~cpu_stall & ~dbg_gnt;
    assign dbg_read = dbg_gnt & ~dbg_we;

    // Owner mux: exactly one requester (or none) drives the DM port.
    always_comb begin
        DM_Address    = '0;
        DM_enable     = 1'b0;
        DM_Write_Data = '0;
        cpu_rdata     = '0;
        if (dbg_gnt) begin
            DM_Address    = dbg_addr;
            DM_enable     = dbg_we;
            DM_Write_Data = dbg_wdata;
        end else if (cpu_owns) begin
            DM_Address    = cpu_addr;
            DM_enable     = cpu_we;
            DM_Write_Data = cpu_wdata;
            cpu_rdata     = DM_Read_Data;
        end
    end

    // Arbiter state, starvation counter, lock counter and debug read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            wait_cnt   <= '0;
            lock_cnt   <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            if (dbg_gnt || !dbg_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            dbg_rvalid <= dbg_read;
            if (dbg_read) begin
                dbg_rdata <= DM_Read_Data;
            end

            case (state)
                ARB: begin
                    if (dbg_gnt && dbg_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!dbg_lock || (lock_cnt == LOCK_LAST)) begin
                        state <= COOLDOWN;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule
